// File: rtl/bitwise_op_pkg.sv
// rtl/bitwise_op_pkg.sv - shared types and constants for the bitwise logic tile (BITOP_ROTATE_EN)
package bitwise_op_pkg;

    localparam int WIDTH = 8;
    localparam logic [7:0] UIO_OE_MASK = 8'hE0;

    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_LOAD_A = 2'b01,
        CMD_LOAD_B = 2'b10,
        CMD_EXEC   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
`ifdef BITOP_ROTATE_EN
        OP_ROL  = 3'b111
`else
        OP_ANDN = 3'b111
`endif
    } op_e;

endpackage

// File: rtl/bitop_core.sv
// rtl/bitop_core.sv - combinational bitwise function unit; op 111 is rotate-left under BITOP_ROTATE_EN
module bitop_core
    import bitwise_op_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

`ifdef BITOP_ROTATE_EN
    logic [2*WIDTH-1:0] rol_wide;

    // Shifting the doubled operand leaves the rotated byte in the upper half.
    assign rol_wide = {a, a} << b[2:0];
`endif

    always_comb begin
        f = '0;
        case (op_e'(op))
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_NAND: f = ~(a & b);
            OP_NOR:  f = ~(a | b);
            OP_XNOR: f = ~(a ^ b);
            OP_NOTA: f = ~a;
`ifdef BITOP_ROTATE_EN
            OP_ROL:  f = rol_wide[2*WIDTH-1:WIDTH];
`else
            OP_ANDN: f = a & ~b;
`endif
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/tt_um_bitwise_operator.sv
// rtl/tt_um_bitwise_operator.sv - TinyTapeout tile: serial-loaded registered bitwise unit (BITOP_ROTATE_EN)
module tt_um_bitwise_operator
    import bitwise_op_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] f_val;
    logic             zero_flag;
    logic             parity_flag;
    logic             done;
    cmd_e             cmd;
    logic             unused_uio;

    assign cmd        = cmd_e'(uio_in[1:0]);
    assign unused_uio = &{1'b0, uio_in[7:5]};

    bitop_core u_core (
        .op (uio_in[4:2]),
        .a  (a_reg),
        .b  (b_reg),
        .f  (f_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            r_reg       <= '0;
            zero_flag   <= 1'b0;
            parity_flag <= 1'b0;
            done        <= 1'b0;
        end else begin
            // done is a one-cycle strobe; only an enabled execute re-asserts it.
            done <= 1'b0;
            if (ena) begin
                case (cmd)
                    CMD_LOAD_A: a_reg <= ui_in;
                    CMD_LOAD_B: b_reg <= ui_in;
                    CMD_EXEC: begin
                        r_reg       <= f_val;
                        zero_flag   <= (f_val == '0);
                        parity_flag <= ^f_val;
                        done        <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign uo_out  = r_reg;
    assign uio_out = {done, parity_flag, zero_flag, 5'b0_0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_bitwise_operator.sv
// tb/tb_tt_um_bitwise_operator.sv - randomized self-checking bench for tt_um_bitwise_operator
module tb_tt_um_bitwise_operator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_bad = 0;

    int m_a = 0, m_b = 0, m_r = 0, m_z = 0, m_p = 0, m_d = 0;

    always #5 clk = ~clk;

    tt_um_bitwise_operator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic int ref_f(input int op, input int a, input int b);
        int v;
        case (op)
            0: v = a & b;
            1: v = a | b;
            2: v = a ^ b;
            3: v = 255 - (a & b);
            4: v = 255 - (a | b);
            5: v = 255 - (a ^ b);
            6: v = 255 - a;
`ifdef BITOP_ROTATE_EN
            default: v = (a * (1 << (b % 8)) + a / (1 << (8 - b % 8))) % 256;
`else
            default: v = a & (255 - b);
`endif
        endcase
        return v & 255;
    endfunction

    function automatic int popcount8(input int v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += (v >> i) & 1;
        return c;
    endfunction

    // One clock: apply inputs, advance the model, compare all outputs just after the edge.
    task automatic step(input logic r, input logic e, input int cmd, input int op, input int data);
        rst_n  = r;
        ena    = e;
        ui_in  = data[7:0];
        uio_in = {3'($urandom_range(0, 7)), op[2:0], cmd[1:0]};
        @(posedge clk);
        if (!r) begin
            m_a = 0; m_b = 0; m_r = 0; m_z = 0; m_p = 0; m_d = 0;
        end else if (!e) begin
            m_d = 0;
        end else begin
            m_d = 0;
            if (cmd == 1) m_a = data & 255;
            else if (cmd == 2) m_b = data & 255;
            else if (cmd == 3) begin
                m_r = ref_f(op, m_a, m_b);
                m_z = (m_r == 0) ? 1 : 0;
                m_p = popcount8(m_r) % 2;
                m_d = 1;
            end
        end
        #1;
        check("uo_out", uo_out, 8'(m_r));
        check("uio_out", uio_out, 8'(m_d * 128 + m_p * 64 + m_z * 32));
        check("uio_oe", uio_oe, 8'hE0);
    endtask

    initial begin
        logic [7:0] hold_r;
        logic [7:0] exp_ops [7];
        exp_ops = '{8'h4A, 8'hDF, 8'h95, 8'hB5, 8'h20, 8'h6A, 8'h35};

        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'hE0);

        step(1, 1, 1, 0, 8'hCA);
        step(1, 1, 2, 0, 8'h5F);
        for (int op = 0; op < 7; op++) begin
            step(1, 1, 3, op, 8'h00);
            check($sformatf("op%0d_res", op), uo_out, exp_ops[op]);
            check($sformatf("op%0d_done", op), {7'b0, uio_out[7]}, 8'h01);
            if (op == 2) check("xor_parity", {7'b0, uio_out[6]}, 8'h00);
        end

`ifdef BITOP_ROTATE_EN
        step(1, 1, 2, 0, 8'h03);
        step(1, 1, 3, 7, 8'h00);
        check("op7_rol", uo_out, 8'h56);
`else
        step(1, 1, 3, 7, 8'h00);
        check("op7_andn", uo_out, 8'h80);
`endif

        step(1, 1, 1, 0, 8'hF0);
        step(1, 1, 2, 0, 8'h0F);
        step(1, 1, 3, 0, 8'h00);
        check("and_zero", uo_out, 8'h00);
        check("and_flags", uio_out, 8'hA0);
        step(1, 1, 3, 2, 8'h00);
        check("xor_ff", uo_out, 8'hFF);
        check("xor_flags", uio_out, 8'h80);
        step(1, 1, 1, 0, 8'h01);
        step(1, 1, 3, 6, 8'h00);
        check("nota_fe", uo_out, 8'hFE);
        check("nota_parity", {7'b0, uio_out[6]}, 8'h01);

        hold_r = uo_out;
        step(1, 0, 3, 1, 8'h00);
        check("ena0_hold", uo_out, hold_r);
        check("ena0_flags", uio_out, 8'h40);
        step(1, 0, 1, 0, 8'h77);
        step(1, 1, 3, 6, 8'h00);
        check("ena0_load", uo_out, 8'hFE);

        step(1, 1, 1, 0, 8'hFF);
        step(1, 1, 2, 0, 8'hFF);
        step(0, 1, 0, 0, 0);
        step(1, 1, 3, 1, 8'h00);
        check("midrst_or", uo_out, 8'h00);
        check("midrst_zero", {7'b0, uio_out[5]}, 8'h01);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
